sha256_digest_reader: RTL

Reads a finished SHA-256 digest out of the eight 32-bit hash-state registers and streams it one word per transfer over a 32-bit valid/ready interface.
- Sits between the compression core's hash registers, which are loaded on `start`, and the downstream consumer (host bus or UART bridge).
- The register bank is the write side of the digest path; this block is its read side.
- Captures a snapshot so the core can begin the next message while the previous digest drains.

---
 rtl/sha256_digest_reader.sv | 81 ++++++++
 1 files changed

// File: rtl/sha256_digest_reader.sv
// rtl/sha256_digest_reader.sv - snapshots a SHA-256 digest and streams it one 32-bit word per transfer
// Optional: SHA256_DIGEST_BYTESWAP_EN byte-reverses each output word for little-endian consumers.
module sha256_digest_reader #(
   parameter int NUM_WORDS = 8
) (
   input  logic                   CLK,
   input  logic                   RST,
   input  logic                   digest_valid,
   input  logic [32*NUM_WORDS-1:0] digest_i,
   output logic                   digest_ready,
   output logic                   out_valid,
   output logic [31:0]            out_data,
   output logic                   out_last,
   input  logic                   out_ready,
   output logic                   busy,
   output logic [2:0]             word_idx
);

   typedef enum logic {IDLE, SEND} state_t;

   localparam logic [2:0] LAST_IDX = 3'(NUM_WORDS - 1);

   state_t                   state;
   logic [32*NUM_WORDS-1:0]  shadow;
   logic [2:0]               idx;
   logic [31:0]              word;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state  <= IDLE;
         shadow <= '0;
         idx    <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (digest_valid) begin
                  shadow <= digest_i;
                  idx    <= '0;
                  state  <= SEND;
               end
            end
            SEND: begin
               if (out_ready) begin
                  if (idx == LAST_IDX) begin
                     idx   <= '0;
                     state <= IDLE;
                  end else begin
                     idx <= idx + 3'd1;
                  end
               end
            end
            default: begin
               state <= IDLE;
               idx   <= '0;
            end
         endcase
      end
   end

   // H0 lives in the top word of the snapshot, so word k counts down from the MSB end.
   always_comb begin
      word = '0;
      for (int k = 0; k < NUM_WORDS; k++) begin
         if (idx == 3'(k))
            word = shadow[32*(NUM_WORDS-k)-1 -: 32];
      end
   end

   assign busy         = (state == SEND);
   assign digest_ready = ~busy;
   assign out_valid    = busy;
   assign out_last     = busy && (idx == LAST_IDX);
   assign word_idx     = idx;

`ifdef SHA256_DIGEST_BYTESWAP_EN
   assign out_data = busy ? {word[7:0], word[15:8], word[23:16], word[31:24]} : 32'd0;
`else
   assign out_data = busy ? word : 32'd0;
`endif

endmodule
